// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch stage and imem.
// Single outstanding request. imem_addr is held while imem_req is high and imem_ready is low.
// Backpressure: imem_ready low holds the request. No data is accepted from an earlier address.
//
// Ports:
//   imem_req   - fetch request. imem_addr is valid while this is high.
//   imem_addr  - word-aligned fetch address.
//   imem_ready - imem_rdata is valid for the current imem_addr this cycle.
//   imem_rdata - returned instruction word.
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   // Fetch-stage side.
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   // Memory side.
   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// Multicycle RV32I fetch stage: owns the PC, fetches one word at a time and holds it for decode.
// Latency: a word returned in cycle N is presented with instr_valid in cycle N+1. Peak rate is one word per 2 cycles.
// Backpressure: imem_ready low holds the stage in REQ. stall high freezes FULL. redirect overrides both.
//
// Ports:
//   clk, rst    - rising-edge clock and synchronous active-high reset.
//   imem        - request/ready bus to instruction memory (master side).
//   stall       - decode holds the current instruction.
//   redirect    - load redirect_pc as the next fetch address.
//   redirect_pc - redirect target. A misaligned target locks the stage in ERROR until reset.
//   Instr       - instruction register.
//   PC          - address of Instr.
//   PCPlus4     - PC + 4, wrapping at 2^32.
//   ImmSrc      - immediate format decoded from the Instr opcode.
//   instr_valid - Instr, PC, PCPlus4 and ImmSrc are valid.
//   fetch_error - sticky misaligned-redirect flag.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master imem,
   input  logic         stall,
   input  logic         redirect,
   input  logic [31:0]  redirect_pc,
   output logic [31:0]  Instr,
   output logic [2:0]   ImmSrc,
   output logic [31:0]  PC,
   output logic [31:0]  PCPlus4,
   output logic         instr_valid,
   output logic         fetch_error
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Opcodes that select a non-I immediate format, or that are I-type.
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_FULL  = 2'd1,
      S_ERROR = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;        // next fetch address
   logic [31:0] instr_q;     // instruction register
   logic [31:0] instr_pc_q;  // address of instr_q
   logic        valid_q;
   logic        error_q;

   logic [31:0] pc_inc_d;
   logic        redir_ok_d;
   logic        redir_bad_d;

   assign pc_inc_d    = pc_q + 32'd4;
   assign redir_ok_d  = redirect && (redirect_pc[1:0] == 2'b00);
   assign redir_bad_d = redirect && (redirect_pc[1:0] != 2'b00);

   // Single-process FSM. Every output other than imem_req, PCPlus4 and ImmSrc
   // comes straight from a register updated here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         instr_q    <= NOP_INSTR;
         instr_pc_q <= RESET_PC;
         valid_q    <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         case (state_q)
            S_REQ: begin
               if (redir_bad_d) begin
                  pc_q    <= redirect_pc;
                  state_q <= S_ERROR;
                  error_q <= 1'b1;
               end else if (redir_ok_d) begin
                  // A word returned in this same cycle belongs to the old
                  // path. Drop it and restart the request at the target.
                  pc_q    <= redirect_pc;
                  state_q <= S_REQ;
               end else if (imem.imem_ready) begin
                  instr_q    <= imem.imem_rdata;
                  instr_pc_q <= pc_q;
                  pc_q       <= pc_inc_d;
                  valid_q    <= 1'b1;
                  state_q    <= S_FULL;
               end
            end
            S_FULL: begin
               if (redir_bad_d) begin
                  pc_q    <= redirect_pc;
                  valid_q <= 1'b0;
                  error_q <= 1'b1;
                  state_q <= S_ERROR;
               end else if (redir_ok_d) begin
                  // The held instruction is dropped even if decode is stalled.
                  pc_q    <= redirect_pc;
                  valid_q <= 1'b0;
                  state_q <= S_REQ;
               end else if (!stall) begin
                  valid_q <= 1'b0;
                  state_q <= S_REQ;
               end
            end
            default: begin
               // ERROR: parked until reset. Redirects are ignored.
               state_q <= S_ERROR;
            end
         endcase
      end
   end

   // The request is held off during reset so that memory never sees a fetch
   // from an address that is about to be replaced.
   assign imem.imem_req  = (state_q == S_REQ) && !rst;
   assign imem.imem_addr = pc_q;

   assign Instr       = instr_q;
   assign PC          = instr_pc_q;
   assign PCPlus4     = instr_pc_q + 32'd4;
   assign instr_valid = valid_q;
   assign fetch_error = error_q;

   always_comb begin
      ImmSrc = IMM_I;
      case (instr_q[6:0])
         OP_LOAD, OP_IMM, OP_JALR: ImmSrc = IMM_I;
         OP_STORE:                 ImmSrc = IMM_S;
         OP_BRANCH:                ImmSrc = IMM_B;
         OP_JAL:                   ImmSrc = IMM_J;
         OP_LUI, OP_AUIPC:         ImmSrc = IMM_U;
         default:                  ImmSrc = IMM_I;
      endcase
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Multicycle instruction-fetch stage for the RV32I core. It owns the program counter, runs a single-outstanding request/ready handshake to instruction memory, and latches each returned word into an instruction register. It presents `Instr`, its `PC`/`PCPlus4` and a decoded `ImmSrc` to the decode stage, so `Instr` and `ImmSrc` drive the immediate extender directly. Stall and redirect come from the datapath controller.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be word-aligned.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `imem_req` out 1: fetch request. `imem_addr` is valid while this is high.
- `imem_addr` out 32: fetch address, equal to `pc_q`.
- `imem_ready` in 1: `imem_rdata` is valid for the current `imem_addr` this cycle.
- `imem_rdata` in 32: instruction word.
- `stall` in 1: downstream holds the current instruction.
- `redirect` in 1: load a new PC (branch/jump taken).
- `redirect_pc` in 32: target PC.
- `Instr` out 32: instruction register.
- `ImmSrc` out 3: immediate format decoded from `Instr[6:0]`.
- `PC` out 32: address of `Instr`.
- `PCPlus4` out 32: `PC + 4`, modulo 2^32.
- `instr_valid` out 1: `Instr`, `PC`, `PCPlus4` and `ImmSrc` are valid.
- `fetch_error` out 1: sticky misaligned-redirect flag.

## Operation
- **States.** REQ, FULL, ERROR.
- **REQ**
  - Outputs: `imem_req`=1, `imem_addr`=`pc_q`, `instr_valid`=0.
  - On `imem_ready`: `Instr`←`imem_rdata`, `PC`←`pc_q`, `pc_q`←`pc_q+4`, go to FULL.
  - Otherwise stay in REQ.
- **FULL**
  - Outputs: `imem_req`=0, `instr_valid`=1.
  - `stall`=1: stay, with all outputs frozen.
  - `stall`=0: the instruction is consumed at this edge; go to REQ.
- **ERROR**
  - Outputs: `imem_req`=0, `instr_valid`=0, `fetch_error`=1.
  - Leaves only on `rst`.
- **Redirect** (any state except ERROR):
  - `redirect`=1 with `redirect_pc[1:0]`=0: `pc_q`←`redirect_pc`, go to REQ, `instr_valid` drops next cycle.
  - `redirect`=1 with `redirect_pc[1:0]`≠0: `pc_q`←`redirect_pc`, go to ERROR.
- **Priority:** `rst` > `redirect` > `imem_ready`/`stall`.
  - `redirect` together with `imem_ready` in REQ: the returned word is discarded and `Instr`/`PC` are unchanged.
  - `redirect` together with `stall`=1 in FULL: the held instruction is dropped.
- **Memory contract:** no transaction is outstanding across cycles. A change of `imem_addr` (redirect, reset) abandons any pending fetch, and no late data is accepted.
- **ImmSrc decode** (combinational from `Instr[6:0]`):
  - 0000011, 0010011, 1100111 → 3'd0 (I).
  - 0100011 → 3'd1 (S).
  - 1100011 → 3'd2 (B).
  - 1101111 → 3'd3 (J).
  - 0110111, 0010111 → 3'd4 (U).
  - All other opcodes → 3'd0.
- **Arithmetic:**
  - `pc_q+4` and `PCPlus4` are 32-bit and wrap: 32'hFFFF_FFFC + 4 = 32'h0.
  - No other PC arithmetic is done here.

## Timing
- **Reset values** (while `rst`=1 and at the edge it is sampled):
  - `pc_q`=`RESET_PC`, state=REQ.
  - `Instr`=32'h0000_0013 (NOP), so `ImmSrc`=3'd0.
  - `PC`=`RESET_PC`, `PCPlus4`=`RESET_PC+4`.
  - `instr_valid`=0, `fetch_error`=0.
  - `imem_req` forced to 0 while `rst`=1.
- **First request:** `imem_req`=1 in the first cycle after `rst` deasserts.
- **Latency:**
  - A request answered in cycle N (zero-wait memory: the cycle it is issued) gives `instr_valid`=1 in cycle N+1.
  - Peak throughput is one instruction per 2 cycles (REQ, FULL, REQ, ...).
  - Each memory wait state adds one cycle in REQ.
- **Registered vs combinational:**
  - `Instr`, `PC`, `pc_q` and the state are registered.
  - `ImmSrc` and `PCPlus4` are combinational from registers.
  - `imem_req` depends only on state and `rst`, never on `stall` or `imem_ready`.
- **Stability:** `imem_addr` is stable for every cycle `imem_req`=1 until `imem_ready`, redirect or reset.
- **Mid-operation reset:** applies at the next edge regardless of state. It clears ERROR and abandons in-flight fetches.

## Test plan
- **Reset and zero-wait fetch.** `RESET_PC`=0, memory returns 32'h00500093 at 0 and 32'h00A12023 at 4, `imem_ready` tied 1, `stall`=0.
  - `instr_valid` is high in cycle 2 with `Instr`=32'h00500093, `PC`=0, `ImmSrc`=0.
  - `instr_valid` is high again in cycle 4 with `Instr`=32'h00A12023, `PC`=4, `ImmSrc`=1.
- **Wait states and stall.** `imem_ready` low for 3 cycles, then high; after capture, `stall`=1 for 5 cycles.
  - `imem_addr` is constant throughout the wait.
  - Outputs are frozen with `imem_req`=0 for the 5 stalled cycles.
  - The next request is issued the cycle after `stall` falls.
- **Redirect priority.** `redirect`=1, `redirect_pc`=32'h100, asserted in the same cycle as `imem_ready` with data 32'hFE000EE3.
  - `Instr` is unchanged.
  - Next cycle: `imem_req`=1, `imem_addr`=32'h100.
  - Fetched B-type word 32'hFE000EE3 then gives `ImmSrc`=2.
- **Misaligned redirect.** `redirect_pc`=32'h102.
  - `fetch_error`=1 and `imem_req`=0 from the next cycle.
  - Held indefinitely.
  - `rst` clears it and restarts at `RESET_PC`.
- **Wrap.** Redirect to 32'hFFFF_FFFC and fetch 32'h0000006F.
  - `PCPlus4`=0 and `ImmSrc`=3.
  - The next request has `imem_addr`=0.
- **Reset mid-wait.** `rst` asserted while in REQ with `imem_ready`=0 and `pc_q`=32'h40.
  - `imem_req`=0 during reset.
  - Restart at `RESET_PC` with `instr_valid`=0.
